mem_access_unit: RTL and testbench

- Data-memory access unit between the CPU's MEM stage and a byte-addressed, word-organised data memory with variable wait states.
- Store direction: narrows and packs a 32-bit register value into the addressed byte/halfword lane and generates byte enables.
- Load direction: extracts the addressed lane from the returned word and sign- or zero-extends it to 32 bits.
- Request/response handshake toward the core, enable/ack handshake toward memory, and an optional timeout.

---
 rtl/mem_access_unit_pkg.sv | 53 +++++
 rtl/ld_lane_ext.sv | 26 ++
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared size codes, FSM state encoding and store-lane packing helpers for mem_access_unit.
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        MAU_IDLE   = 2'd0,
        MAU_ACCESS = 2'd1,
        MAU_RESP   = 2'd2
    } mau_state_t;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
    } store_pack_t;

    // Misaligned halfword/word offsets fall onto the aligned lane because
    // the half enable shift ignores off[0] and word always enables all lanes.
    function automatic store_pack_t pack_store(input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic [31:0] wdata);
        store_pack_t p;
        case (size)
            SIZE_BYTE: begin
                p.wdata = {4{wdata[7:0]}};
                p.be    = 4'b0001 << off;
            end
            SIZE_HALF: begin
                p.wdata = {2{wdata[15:0]}};
                p.be    = 4'b0011 << {off[1], 1'b0};
            end
            default: begin
                p.wdata = wdata;
                p.be    = 4'b1111;
            end
        endcase
        return p;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = off[0];
            default:   mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ld_lane_ext.sv
// Load lane extractor: selects the addressed byte/halfword of a memory word and sign/zero-extends it.
module ld_lane_ext
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] result
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        lane8  = 8'(rdata >> {offset, 3'b000});
        lane16 = offset[1] ? rdata[31:16] : rdata[15:0];
        result = rdata;
        case (size)
            SIZE_BYTE: result = {{24{sext & lane8[7]}}, lane8};
            SIZE_HALF: result = {{16{sext & lane16[15]}}, lane16};
            default:   result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: core req/rsp handshake to memory en/ack with store packing and load extension.
// Optional macro MISALIGN_TRAP_EN turns misaligned requests into error responses without a memory access.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_en,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CNT_W    = $clog2(TIMEOUT_CYC + 2);
    localparam int TO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

    mau_state_t       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [1:0]       off_q, size_q;
    logic             sext_q, we_q;

    logic             mem_en_d;
    logic [3:0]       mem_be_d;
    logic [31:0]      mem_addr_d, mem_wdata_d;
    logic             rsp_valid_d;
    logic [31:0]      rsp_rdata_d;
    logic             rsp_err_d;

    logic             accept, misalign, timeout_hit;
    logic [31:0]      ld_data;
    store_pack_t      pk;

    assign req_ready = (state == MAU_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign pk        = pack_store(req_size, req_addr[1:0], req_wdata);

`ifdef MISALIGN_TRAP_EN
    assign misalign = is_misaligned(req_size, req_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // cnt counts ACCESS cycles already spent without ack, so the timeout
    // fires on the TIMEOUT_CYC-th such cycle; an ack in that cycle still wins.
    assign timeout_hit = (TIMEOUT_CYC > 0) && (cnt == TO_LAST);

    ld_lane_ext u_ld_lane_ext (
        .rdata  (mem_rdata),
        .offset (off_q),
        .size   (size_q),
        .sext   (sext_q),
        .result (ld_data)
    );

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        mem_en_d    = 1'b0;
        mem_be_d    = mem_be;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        case (state)
            MAU_IDLE: begin
                if (accept) begin
                    mem_addr_d  = {req_addr[31:2], 2'b00};
                    mem_be_d    = req_we ? pk.be : 4'b0000;
                    mem_wdata_d = pk.wdata;
                    cnt_d       = '0;
                    if (misalign) begin
                        state_d     = MAU_RESP;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d  = MAU_ACCESS;
                        mem_en_d = 1'b1;
                    end
                end
            end
            MAU_ACCESS: begin
                if (mem_ack) begin
                    state_d     = MAU_RESP;
                    rsp_rdata_d = we_q ? 32'd0 : ld_data;
                    rsp_err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = MAU_RESP;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    mem_en_d = 1'b1;
                    cnt_d    = cnt + 1'b1;
                end
            end
            MAU_RESP: state_d = MAU_IDLE;
            default:  state_d = MAU_IDLE;
        endcase
        rsp_valid_d = (state_d == MAU_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MAU_IDLE;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            mem_en    <= mem_en_d;
            mem_be    <= mem_be_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

    // Request attributes used only for load extraction; no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            off_q  <= req_addr[1:0];
            size_q <= req_size;
            sext_q <= req_sext;
            we_q   <= req_we;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: random and directed requests against an arithmetic reference model.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_sext;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        mem_en, mem_ack;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_sext  (req_sext),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_en    (mem_en),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    rsp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic [1:0] o,
                                               input logic sext, input logic [31:0] rd);
        longint v;
        if (size == 2'd0) begin
            v = (rd >> (8 * o)) & 32'hFF;
            if (sext && v >= 128) v = v - 256;
        end else if (size == 2'd1) begin
            v = (rd >> (16 * (o / 2))) & 32'hFFFF;
            if (sext && v >= 32768) v = v - 65536;
        end else begin
            v = rd;
        end
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] o);
        int b;
        if (size == 2'd0)      b = 1 << o;
        else if (size == 2'd1) b = 3 << (o & 2);
        else                   b = 15;
        return b[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0)      return (wd & 32'hFF) * 32'h01010101;
        else if (size == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        else                   return wd;
    endfunction

    // d = index of the ACCESS cycle carrying mem_ack; d >= TO means no ack at all.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int d);
        rsp_t e;
        logic mis;
        int   last;
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (size == 2'd1 && addr[0]) || (size >= 2'd2 && addr[1:0] != 2'b00);
`endif
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_sext  = sext;
        req_addr  = addr;
        req_wdata = wdata;
        check("req_ready_idle", req_ready, 1);
        if (mis)          e = '{32'd0, 1'b1, cyc + 1};
        else if (d >= TO) e = '{32'd0, 1'b1, cyc + 1 + TO};
        else              e = '{(we ? 32'd0 : model_load(size, addr[1:0], sext, rdata)), 1'b0, cyc + 2 + d};
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        if (mis) begin
            check("trap_mem_en", mem_en, 0);
        end else begin
            last = (d < TO) ? d : TO - 1;
            for (int k = 0; k <= last; k++) begin
                check("mem_en", mem_en, 1);
                check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check("mem_be", mem_be, we ? model_be(size, addr[1:0]) : 4'b0000);
                if (we) check("mem_wdata", mem_wdata, model_wdata(size, wdata));
                mem_ack   = (k == d);
                mem_rdata = (k == d) ? rdata : $urandom;
                @(negedge clk);
            end
            mem_ack = 1'b0;
            check("resp_mem_en", mem_en, 0);
        end
        @(negedge clk);
        check("ready_after_rsp", req_ready, 1);
    endtask

    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp actual=rsp_valid required=no response (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sext = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        check("reset_req_ready", req_ready, 0);
        @(negedge clk);
        check("reset_mem_en", mem_en, 0);
        check("reset_mem_be", mem_be, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_rsp_err", rsp_err, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", req_ready, 1);

        do_req(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1);
        do_req(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0);
        do_req(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 0);
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_0001, 32'h0, 32'h0000_F700, 3);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, TO + 2);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, TO - 1);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 32'hCAFE_BABE, 1);
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_0103, 32'hDEAD_BEEF, 32'h0, 0);

        // Reset during a wait must abort silently.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h40;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_mem_en_before", mem_en, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_mem_en", mem_en, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        repeat (3) @(negedge clk);
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0042, 32'h0, 32'h00AA_0000, 2);

        for (int i = 0; i < 150; i++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, TO + 1)));
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
